// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: buffers {PC+4, instruction} pairs,
// presents the oldest pair first-word-fall-through, stalls fetch when full, drops all on flush.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_instr,
  output logic              pc_write,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              err_ovf
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_ovf_q, err_ovf_d;
  logic [DATA_W-1:0] pc4_mem_q   [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];

  logic full_s, empty_s, push_s, pop_s, wr_en_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);
  assign push_s  = in_valid & ~full_s;
  assign pop_s   = ~empty_s & out_ready;
  assign wr_en_s = push_s & ~flush & Reset;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    if (flush) begin
      // Redirect discards everything queued; the overflow flag survives.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (in_valid && full_s) err_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Storage is never reset; stale words are hidden by the empty mask below.
  always_ff @(posedge Clk) begin
    if (wr_en_s) begin
      pc4_mem_q[wr_ptr_q]   <= in_pc4;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  assign pc_write  = ~full_s;
  assign out_valid = ~empty_s;
  assign out_pc4   = empty_s ? '0 : pc4_mem_q[rd_ptr_q];
  assign out_instr = empty_s ? '0 : instr_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based scoreboard of expected head words.
module tb_if_id_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_pc4 = '0;
  logic [DATA_W-1:0] in_instr = '0;
  logic              pc_write;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_pc4;
  logic [DATA_W-1:0] out_instr;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   count;
  logic              err_ovf;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] sb_q [$];
  logic        err_exp = 1'b0;

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_pc4(in_pc4),
    .in_instr(in_instr), .pc_write(pc_write), .flush(flush),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_instr(out_instr),
    .out_ready(out_ready), .count(count), .err_ovf(err_ovf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb_q.size();
    check({tag, ".count"}, 64'(count), 64'(n));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    check({tag, ".pc_write"}, 64'(pc_write), 64'(n < DEPTH));
    check({tag, ".err_ovf"}, 64'(err_ovf), 64'(err_exp));
    if (n != 0) begin
      check({tag, ".out_pc4"}, 64'(out_pc4), 64'(sb_q[0][63:32]));
      check({tag, ".out_instr"}, 64'(out_instr), 64'(sb_q[0][31:0]));
    end else begin
      check({tag, ".out_pc4"}, 64'(out_pc4), 64'd0);
      check({tag, ".out_instr"}, 64'(out_instr), 64'd0);
    end
  endtask

  // One cycle: drive at negedge, check pre-edge outputs, clock, update model.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc4,
                       input logic [31:0] instr, input logic rdy, input logic fl);
    int  n;
    logic do_push, do_pop;
    in_valid = v; in_pc4 = pc4; in_instr = instr; out_ready = rdy; flush = fl;
    #1;
    check_state(tag);
    n = sb_q.size();
    do_push = v && (n < DEPTH);
    do_pop  = rdy && (n > 0);
    @(posedge Clk);
    if (fl) begin
      sb_q.delete();
    end else begin
      if (v && n == DEPTH) err_exp = 1'b1;
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back({pc4, instr});
    end
    @(negedge Clk);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0; in_valid = 1'b1; in_pc4 = 32'hDEAD; in_instr = 32'hBEEF;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    sb_q.delete();
    err_exp = 1'b0;
    in_valid = 1'b0;
    #1;
    check_state(tag);
  endtask

  initial begin
    // 1: reset with in_valid high
    @(negedge Clk);
    do_reset("rst");

    // 2: fill 3 while stalled, then drain in order
    cycle("t2p0", 1'b1, 32'd4,  32'h2008_0001, 1'b0, 1'b0);
    cycle("t2p1", 1'b1, 32'd8,  32'h2009_0002, 1'b0, 1'b0);
    cycle("t2p2", 1'b1, 32'd12, 32'h200A_0003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t2d", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle("t2e", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // 3: fill to full, then overflow attempt
    for (int i = 0; i < 4; i++)
      cycle("t3p", 1'b1, 32'(16 + 4 * i), 32'hA000_0000 | 32'(i), 1'b0, 1'b0);
    cycle("t3ovf", 1'b1, 32'h99, 32'h99, 1'b0, 1'b0);
    cycle("t3post", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("t3d", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // 4: simultaneous push and pop at count=2
    cycle("t4p0", 1'b1, 32'd100, 32'hB000_0000, 1'b0, 1'b0);
    cycle("t4p1", 1'b1, 32'd104, 32'hB000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("t4pp", 1'b1, 32'(108 + 4 * i), 32'hB000_0002 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle("t4d", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // 5: flush at count=3 beats push and pop
    for (int i = 0; i < 3; i++)
      cycle("t5p", 1'b1, 32'(200 + 4 * i), 32'hC000_0000 | 32'(i), 1'b0, 1'b0);
    cycle("t5fl", 1'b1, 32'd300, 32'hC000_00FF, 1'b1, 1'b1);
    cycle("t5post", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // 6: stream 10 words across pointer wrap, then reset mid-operation
    for (int i = 1; i <= 10; i++)
      cycle("t6s", 1'b1, 32'(4 * i), 32'hD000_0000 | 32'(i), 1'b1, 1'b0);
    cycle("t6e", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("t6f", 1'b1, 32'(400 + 4 * i), 32'hE000_0000 | 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      cycle("t6ovf", 1'b1, 32'(500 + 4 * i), 32'hE100_0000, 1'b0, 1'b0);
    cycle("t6d", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    do_reset("t6rst");
    cycle("t6after", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
